fifo_byte_serializer: RTL and testbench

FIFO_BYTE_SERIALIZER -- requirements
Module: fifo_byte_serializer

---
 rtl/fifo_byte_serializer.sv | 105 ++++++++++
 tb/tb_fifo_byte_serializer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_serializer.sv
// Pulls words from a show-ahead-less FIFO and emits them LSB-first as byte_w-wide
// symbols over a valid/ready stream, one FETCH bubble between words.
module fifo_byte_serializer #(
    parameter int width  = 32,
    parameter int byte_w = 8
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [width-1:0]  fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [byte_w-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    localparam int N     = width / byte_w;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if ((width % byte_w) != 0 || width < byte_w) begin : g_badParam
        $error("fifo_byte_serializer: width must be a non-zero multiple of byte_w");
    end

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [width-1:0]  r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_inSend;
    logic              w_lastSym;
    logic              w_handshake;
    logic              w_rdEn;

    assign w_inSend    = (r_state == SEND);
    assign w_lastSym   = w_inSend && (r_cnt == LAST_CNT);
    assign w_handshake = w_inSend && out_ready;

    // The read strobe is only issued from IDLE or on the final handshake of a word,
    // so the next word lands exactly in the FETCH cycle that follows.
    always_comb begin
        w_nextState = r_state;
        w_rdEn      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!fifo_empty) begin
                    w_rdEn      = 1'b1;
                    w_nextState = FETCH;
                end
            end
            FETCH: begin
                w_nextState = SEND;
            end
            SEND: begin
                if (w_handshake && w_lastSym) begin
                    if (!fifo_empty) begin
                        w_rdEn      = 1'b1;
                        w_nextState = FETCH;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Symbol 0 always sits in the low bits; each accepted symbol shifts the next one down.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (r_state == FETCH) begin
            r_shift <= fifo_data;
            r_cnt   <= '0;
        end else if (w_handshake && !w_lastSym) begin
            r_shift <= r_shift >> byte_w;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign fifo_rd_en = w_rdEn & rst_n;
    assign out_valid  = w_inSend;
    assign out_data   = w_inSend ? r_shift[byte_w-1:0] : '0;
    assign out_last   = w_lastSym;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Self-checking bench: a queue-backed FIFO model feeds the serializer and a
// scoreboard of expected symbols is compared on every output handshake.
module tb_fifo_byte_serializer;

    logic        sys_clk;
    logic        rst_n;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } sym_t;

    logic [31:0] fifoQ[$];
    sym_t        expQ[$];
    sym_t        monSym;
    int          pushCount;
    int          popCount;
    int          rdEnCount;
    logic        forceEmpty;
    int          checkCount;
    int          failCount;

    fifo_byte_serializer #(.width(32), .byte_w(8)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    assign fifo_empty = forceEmpty | ((pushCount - popCount) == 0);

    // FIFO model: read data appears the cycle after the strobe.
    always @(posedge sys_clk) begin
        if (fifo_rd_en && fifoQ.size() > 0) begin
            fifo_data <= fifoQ.pop_front();
            popCount  <= popCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge sys_clk) begin
        if (rst_n) begin
            checkOutput("rdEnGuard", {31'b0, fifo_rd_en & fifo_empty}, 32'd0);
            if (!out_valid) checkOutput("idleData", {24'b0, out_data}, 32'd0);
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("extraSymbol", {24'b0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    monSym = expQ.pop_front();
                    checkOutput("symData", {24'b0, out_data}, {24'b0, monSym.data});
                    checkOutput("symLast", {31'b0, out_last}, {31'b0, monSym.last});
                end
            end
        end else begin
            checkOutput("rdEnInReset", {31'b0, fifo_rd_en}, 32'd0);
        end
        if (fifo_rd_en) rdEnCount++;
    end

    task automatic nextNeg;
        @(negedge sys_clk);
    endtask

    task automatic atDrive;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        sym_t s;
        fifoQ.push_back(word);
        pushCount++;
        for (int i = 0; i < 4; i++) begin
            s.data = word[i*8 +: 8];
            s.last = (i == 3);
            expQ.push_back(s);
        end
    endtask

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 60; i++) begin
            nextNeg();
            if (!busy && !fifo_rd_en && expQ.size() == 0) break;
        end
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_drained"}, expQ.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [10:0] validVec;
        logic [10:0] rdVec;
        logic        quietAcc;

        checkCount = 0;
        failCount  = 0;
        pushCount  = 0;
        popCount   = 0;
        rdEnCount  = 0;
        forceEmpty = 1'b0;
        fifo_data  = '0;
        out_ready  = 1'b1;
        rst_n      = 1'b0;

        // Reset state
        atDrive();
        atDrive();
        nextNeg();
        checkOutput("rstValid", {31'b0, out_valid}, 32'd0);
        checkOutput("rstData", {24'b0, out_data}, 32'd0);
        checkOutput("rstLast", {31'b0, out_last}, 32'd0);
        checkOutput("rstBusy", {31'b0, busy}, 32'd0);
        checkOutput("rstRdEn", {31'b0, fifo_rd_en}, 32'd0);
        atDrive();
        rst_n = 1'b1;

        // Empty FIFO stays quiet
        quietAcc = 1'b0;
        repeat (20) begin
            nextNeg();
            quietAcc = quietAcc | fifo_rd_en | out_valid | busy;
        end
        checkOutput("emptyQuiet", {31'b0, quietAcc}, 32'd0);

        // Single word
        atDrive();
        rdEnCount = 0;
        applyStimulus(32'h4433_2211);
        nextNeg();
        checkOutput("singleRdEn", {31'b0, fifo_rd_en}, 32'd1);
        nextNeg();
        checkOutput("singleFetchValid", {31'b0, out_valid}, 32'd0);
        checkOutput("singleFetchBusy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            nextNeg();
            checkOutput("singleValid", {31'b0, out_valid}, 32'd1);
        end
        nextNeg();
        checkOutput("singleDoneBusy", {31'b0, busy}, 32'd0);
        checkOutput("singleDoneValid", {31'b0, out_valid}, 32'd0);
        checkOutput("singleRdEnCount", rdEnCount, 32'd1);

        // Backpressure while showing 0x22
        atDrive();
        rdEnCount = 0;
        applyStimulus(32'h4433_2211);
        nextNeg();
        nextNeg();
        nextNeg();
        atDrive();
        out_ready = 1'b0;
        repeat (3) begin
            nextNeg();
            checkOutput("bpValid", {31'b0, out_valid}, 32'd1);
            checkOutput("bpData", {24'b0, out_data}, 32'h22);
            checkOutput("bpLast", {31'b0, out_last}, 32'd0);
            checkOutput("bpRdEn", {31'b0, fifo_rd_en}, 32'd0);
            atDrive();
        end
        out_ready = 1'b1;
        waitIdle("bp");
        checkOutput("bpRdEnCount", rdEnCount, 32'd1);

        // Back-to-back words with one bubble
        atDrive();
        rdEnCount = 0;
        applyStimulus(32'hDDCC_BBAA);
        applyStimulus(32'h0403_0201);
        for (int i = 0; i < 11; i++) begin
            nextNeg();
            validVec[i] = out_valid;
            rdVec[i]    = fifo_rd_en;
        end
        checkOutput("b2bValidTrace", {21'b0, validVec}, {21'b0, 11'b111_1011_1100});
        checkOutput("b2bRdEnTrace", {21'b0, rdVec}, {21'b0, 11'b000_0010_0001});
        waitIdle("b2b");
        checkOutput("b2bRdEnCount", rdEnCount, 32'd2);

        // Reset mid-word after symbol 0x22
        atDrive();
        rdEnCount = 0;
        applyStimulus(32'h4433_2211);
        nextNeg();
        nextNeg();
        nextNeg();
        nextNeg();
        atDrive();
        rst_n = 1'b0;
        expQ.delete();
        applyStimulus(32'h8877_6655);
        nextNeg();
        atDrive();
        nextNeg();
        checkOutput("midRstValid", {31'b0, out_valid}, 32'd0);
        checkOutput("midRstData", {24'b0, out_data}, 32'd0);
        checkOutput("midRstBusy", {31'b0, busy}, 32'd0);
        checkOutput("midRstRdEn", {31'b0, fifo_rd_en}, 32'd0);
        atDrive();
        nextNeg();
        checkOutput("midRstRdEnHeld", {31'b0, fifo_rd_en}, 32'd0);
        atDrive();
        rst_n = 1'b1;
        nextNeg();
        checkOutput("postRstRdEn", {31'b0, fifo_rd_en}, 32'd1);
        waitIdle("midRst");
        checkOutput("midRstRdEnCount", rdEnCount, 32'd2);

        // Empty rises in the same cycle as the final handshake
        atDrive();
        rdEnCount = 0;
        applyStimulus(32'h4433_2211);
        applyStimulus(32'h8877_6655);
        repeat (5) nextNeg();
        atDrive();
        forceEmpty = 1'b1;
        nextNeg();
        checkOutput("raceLast", {31'b0, out_last}, 32'd1);
        checkOutput("raceRdEn", {31'b0, fifo_rd_en}, 32'd0);
        atDrive();
        forceEmpty = 1'b0;
        nextNeg();
        checkOutput("raceIdleBusy", {31'b0, busy}, 32'd0);
        checkOutput("raceIdleRdEn", {31'b0, fifo_rd_en}, 32'd1);
        waitIdle("race");
        checkOutput("raceRdEnCount", rdEnCount, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
